// File: rtl/prio_irq_ctrl.sv
// 10-line priority interrupt controller: synchronised active-low requests are
// latched as pending, masked, and the highest index is handed to the host via ack/eoi.
module prio_irq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] req_n,
  input  logic [9:0] mask,
  input  logic       en,
  input  logic       ack,
  input  logic       eoi,
  output logic       irq,
  output logic [3:0] vec,
  output logic       vec_valid,
  output logic [9:0] pending,
  output logic [9:0] in_service
);

  localparam int N_LINES = 10;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] SERV = 2'd2;

  logic [SYNC_STAGES-1:0][N_LINES-1:0] r_sync;
  logic [N_LINES-1:0]                  r_sync_d;
  logic [N_LINES-1:0]                  r_pending;
  logic [N_LINES-1:0]                  r_in_service;
  logic [1:0]                          r_state;
  logic                                r_irq;
  logic [3:0]                          r_vec;
  logic                                r_vec_valid;

  logic [N_LINES-1:0] w_synced;
  logic [N_LINES-1:0] w_new_req;
  logic [N_LINES-1:0] w_elig;
  logic [N_LINES-1:0] w_capture_oh;
  logic [3:0]         w_win;
  logic               w_any;
  logic               w_capture;

  // NOTE: synchroniser flops reset to 1 so a released reset never looks like a request edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '1;
      r_sync_d <= '1;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], req_n};
      r_sync_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_synced  = r_sync[SYNC_STAGES-1];
  // Edge mode looks for a high-to-low step of the synchronised line.
  assign w_new_req = EDGE_MODE ? (r_sync_d & ~w_synced) : ~w_synced;

  assign w_elig = en ? (r_pending & ~mask) : '0;
  assign w_any  = |w_elig;

  always_comb begin
    // NOTE: default assignment first, otherwise the loop would infer a latch.
    w_win = '0;
    for (int i = 0; i < N_LINES; i++) begin
      if (w_elig[i]) w_win = 4'(i);
    end
  end

  assign w_capture    = (r_state == REQ) && w_any && ack;
  assign w_capture_oh = w_capture ? (10'(1) << w_win) : '0;

  // A capture in the same cycle as a new request on that line drops the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      // NOTE: non-blocking assignments for all registered state.
      r_pending <= (r_pending | (w_new_req & ~r_in_service)) & ~w_capture_oh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_irq        <= 1'b0;
      r_vec        <= '0;
      r_vec_valid  <= 1'b0;
      r_in_service <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= REQ;
            r_irq   <= 1'b1;
          end
        end
        REQ: begin
          if (!w_any) begin
            r_state <= IDLE;
            r_irq   <= 1'b0;
          end else if (ack) begin
            r_state      <= SERV;
            r_irq        <= 1'b0;
            r_vec        <= w_win;
            r_vec_valid  <= 1'b1;
            r_in_service <= w_capture_oh;
          end
        end
        SERV: begin
          if (eoi) begin
            r_state      <= IDLE;
            r_vec_valid  <= 1'b0;
            r_in_service <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  assign irq        = r_irq;
  assign vec        = r_vec;
  assign vec_valid  = r_vec_valid;
  assign pending    = r_pending;
  assign in_service = r_in_service;

endmodule

// File: tb/tb_prio_irq_ctrl.sv
// Directed bench for prio_irq_ctrl: level and edge instances share stimulus and are
// compared every cycle against a phase-level behavioural model, plus literal checks.
module tb_prio_irq_ctrl;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] req_n;
  logic [9:0] mask;
  logic       en, ack, eoi;

  logic       irq_l, vv_l, irq_e, vv_e;
  logic [3:0] vec_l, vec_e;
  logic [9:0] pend_l, isv_l, pend_e, isv_e;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  prio_irq_ctrl #(.SYNC_STAGES(SS), .EDGE_MODE(1'b0)) dut_lvl (
    .clk(clk), .rst_n(rst_n), .req_n(req_n), .mask(mask), .en(en), .ack(ack), .eoi(eoi),
    .irq(irq_l), .vec(vec_l), .vec_valid(vv_l), .pending(pend_l), .in_service(isv_l)
  );

  prio_irq_ctrl #(.SYNC_STAGES(SS), .EDGE_MODE(1'b1)) dut_edge (
    .clk(clk), .rst_n(rst_n), .req_n(req_n), .mask(mask), .en(en), .ack(ack), .eoi(eoi),
    .irq(irq_e), .vec(vec_e), .vec_valid(vv_e), .pending(pend_e), .in_service(isv_e)
  );

  // Model: phase 0 = nothing raised, 1 = waiting for ack, 2 = serving the captured line.
  typedef struct packed {
    int         phase;
    logic [3:0] line;
    logic [3:0] vec;
    logic [9:0] pend;
  } mstate_t;

  mstate_t    ms [2];
  logic [9:0] hist [0:SS];

  function automatic logic [9:0] m_insvc(input mstate_t s);
    return (s.phase == 2) ? (10'(1) << s.line) : 10'(0);
  endfunction

  function automatic mstate_t step(input mstate_t cur, input logic [9:0] synced,
                                   input logic [9:0] prev, input bit edge_mode,
                                   input logic [9:0] mask_v, input logic en_v,
                                   input logic ack_v, input logic eoi_v);
    mstate_t    nx;
    logic [9:0] elig, fresh;
    int         win;
    nx    = cur;
    elig  = en_v ? (cur.pend & ~mask_v) : 10'(0);
    win   = -1;
    for (int i = 0; i < 10; i++) if (elig[i]) win = i;
    fresh = edge_mode ? (prev & ~synced) : ~synced;
    nx.pend = cur.pend | (fresh & ~m_insvc(cur));
    case (cur.phase)
      0: if (win >= 0) nx.phase = 1;
      1: begin
        if (win < 0) nx.phase = 0;
        else if (ack_v) begin
          nx.phase     = 2;
          nx.line      = 4'(win);
          nx.vec       = 4'(win);
          nx.pend[win] = 1'b0;
        end
      end
      default: if (eoi_v) nx.phase = 0;
    endcase
    return nx;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) ms[m] <= '0;
      for (int k = 0; k <= SS; k++) hist[k] <= '1;
    end else begin
      for (int m = 0; m < 2; m++)
        ms[m] <= step(ms[m], hist[SS-1], hist[SS], (m == 1), mask, en, ack, eoi);
      hist[0] <= req_n;
      for (int k = 1; k <= SS; k++) hist[k] <= hist[k-1];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("mdl_lvl_irq",  32'(irq_l),  32'(ms[0].phase == 1));
      check("mdl_lvl_vv",   32'(vv_l),   32'(ms[0].phase == 2));
      check("mdl_lvl_vec",  32'(vec_l),  32'(ms[0].vec));
      check("mdl_lvl_pend", 32'(pend_l), 32'(ms[0].pend));
      check("mdl_lvl_isv",  32'(isv_l),  32'(m_insvc(ms[0])));
      check("mdl_edg_irq",  32'(irq_e),  32'(ms[1].phase == 1));
      check("mdl_edg_vv",   32'(vv_e),   32'(ms[1].phase == 2));
      check("mdl_edg_vec",  32'(vec_e),  32'(ms[1].vec));
      check("mdl_edg_pend", 32'(pend_e), 32'(ms[1].pend));
      check("mdl_edg_isv",  32'(isv_e),  32'(m_insvc(ms[1])));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    @(negedge clk);
    eoi = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; req_n = '1; mask = '0; en = 1'b1; ack = 1'b0; eoi = 1'b0;
    #2 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    cyc(2);
    check("rst_irq",  32'(irq_l),  32'd0);
    check("rst_vv",   32'(vv_l),   32'd0);
    check("rst_vec",  32'(vec_l),  32'd0);
    check("rst_pend", 32'(pend_l), 32'd0);
    check("rst_isv",  32'(isv_l),  32'd0);
    rst_n = 1'b1;
    cyc(1);

    // Single request on line 2: irq on edge 4, then ack/eoi.
    req_n = 10'b1111111011;
    cyc(3); check("t1_irq_e3", 32'(irq_l), 32'd0);
    cyc(1); check("t1_irq_e4", 32'(irq_l), 32'd1);
    pulse_ack();
    check("t1_vec", 32'(vec_l), 32'd2);
    check("t1_vv",  32'(vv_l),  32'd1);
    check("t1_isv", 32'(isv_l), 32'b0000000100);
    check("t1_irq", 32'(irq_l), 32'd0);
    req_n = '1;
    cyc(3);
    pulse_eoi();
    check("t1_eoi_vv",  32'(vv_l),  32'd0);
    check("t1_eoi_vec", 32'(vec_l), 32'd2);
    cyc(2);

    // Lines 2 and 7 together: 7 first, 2 right after eoi.
    req_n = 10'b1101111011;
    cyc(4); check("t2_irq", 32'(irq_l), 32'd1);
    pulse_ack();
    check("t2_vec7",  32'(vec_l),  32'd7);
    check("t2_pend2", 32'(pend_l), 32'b0000000100);
    req_n = '1;
    cyc(3);
    pulse_eoi();
    check("t2_gap",  32'(irq_l), 32'd0);
    cyc(1); check("t2_rerise", 32'(irq_l), 32'd1);
    pulse_ack();
    check("t2_vec2",  32'(vec_l),  32'd2);
    check("t2_pend0", 32'(pend_l), 32'd0);
    cyc(1); pulse_eoi(); cyc(2);

    // Masked line 3, then unmask, then drop en while in REQ.
    mask = 10'b0000001000; req_n = 10'b1111110111;
    cyc(6);
    check("t3_masked_irq", 32'(irq_l),  32'd0);
    check("t3_masked_pnd", 32'(pend_l), 32'b0000001000);
    mask = '0;
    cyc(1); check("t3_unmask_irq", 32'(irq_l), 32'd1);
    en = 1'b0;
    cyc(1);
    check("t3_en0_irq",  32'(irq_l),  32'd0);
    check("t3_en0_pend", 32'(pend_l), 32'b0000001000);
    check("t3_en0_vv",   32'(vv_l),   32'd0);
    cyc(1); check("t3_en0_idle", 32'(irq_l), 32'd0);
    en = 1'b1;
    cyc(1); check("t3_en1_irq", 32'(irq_l), 32'd1);
    req_n = '1;
    cyc(3);
    pulse_ack(); check("t3_vec", 32'(vec_l), 32'd3);
    cyc(1); pulse_eoi(); cyc(2);

    // Line 5 held low: edge mode serves once, level mode re-pends after eoi.
    req_n = 10'b1111011111;
    cyc(4);
    check("t4_lvl_irq", 32'(irq_l), 32'd1);
    check("t4_edg_irq", 32'(irq_e), 32'd1);
    pulse_ack();
    check("t4_lvl_vec", 32'(vec_l), 32'd5);
    check("t4_edg_vec", 32'(vec_e), 32'd5);
    cyc(2);
    pulse_eoi();
    check("t4_edg_vv0", 32'(vv_e), 32'd0);
    cyc(2);
    check("t4_lvl_again", 32'(irq_l),  32'd1);
    check("t4_edg_quiet", 32'(irq_e),  32'd0);
    check("t4_edg_pend0", 32'(pend_e), 32'd0);
    cyc(4); check("t4_edg_still", 32'(irq_e), 32'd0);
    req_n = '1;
    cyc(3);
    req_n = 10'b1111011111;
    cyc(4);
    check("t4_edg_refall", 32'(irq_e), 32'd1);
    check("t4_lvl_req",    32'(irq_l), 32'd1);
    pulse_ack();
    check("t4_edg_vec2", 32'(vec_e), 32'd5);
    req_n = '1;
    cyc(3); pulse_eoi(); cyc(2);
    check("t4_lvl_idle", 32'(irq_l), 32'd0);
    check("t4_edg_idle", 32'(irq_e), 32'd0);

    // Serving line 4: extra ack ignored, line 9 waits until eoi.
    req_n = 10'b1111101111;
    cyc(4); pulse_ack();
    check("t5_vec4", 32'(vec_l), 32'd4);
    check("t5_vv",   32'(vv_l),  32'd1);
    req_n = 10'b0111101111; ack = 1'b1;
    cyc(1); ack = 1'b0;
    cyc(3);
    check("t5_vec_held", 32'(vec_l),  32'd4);
    check("t5_pend9",    32'(pend_l), 32'b1000000000);
    check("t5_irq0",     32'(irq_l),  32'd0);
    check("t5_isv4",     32'(isv_l),  32'b0000010000);
    req_n = 10'b0111111111;
    cyc(3);
    pulse_eoi();
    check("t5_eoi_idle", 32'(irq_l), 32'd0);
    cyc(1); check("t5_irq9", 32'(irq_l), 32'd1);
    pulse_ack(); check("t5_vec9", 32'(vec_l), 32'd9);
    req_n = '1;
    cyc(3); pulse_eoi(); cyc(2);

    // Asynchronous reset in SERV with line 1 pending, then recovery.
    req_n = 10'b1111110111;
    cyc(4); pulse_ack();
    check("t6_serv", 32'(vv_l), 32'd1);
    req_n = 10'b1111111101;
    cyc(4); check("t6_pend1", 32'(pend_l), 32'b0000000010);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_irq",  32'(irq_l),  32'd0);
    check("t6_async_vv",   32'(vv_l),   32'd0);
    check("t6_async_pend", 32'(pend_l), 32'd0);
    check("t6_async_isv",  32'(isv_l),  32'd0);
    check("t6_async_epnd", 32'(pend_e), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3); check("t6_rel_e3", 32'(irq_l), 32'd0);
    cyc(1);
    check("t6_rel_e4",     32'(irq_l), 32'd1);
    check("t6_rel_e4_edg", 32'(irq_e), 32'd1);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
